// File: rtl/msg_unpadding.sv
// msg_unpadding: strips SM3 padding from 512-bit blocks and streams the message as big-endian 32-bit words.
// Define MSG_UNPAD_CHECK_EN to compile in padding validation (pad_error_out); otherwise it is tied low.
module msg_unpadding #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic [511:0]     block_in,
    input  logic             block_valid_in,
    input  logic             block_last_in,
    output logic             block_ready_out,
    output logic [WIDTH-1:0] msg_out,
    output logic             msg_valid_out,
    input  logic             msg_ready_in,
    output logic             is_last_word_out,
    output logic [1:0]       last_word_byte_out,
    output logic             unpad_done_out,
    output logic             msg_empty_out,
    output logic             pad_error_out
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EMIT, S_TAIL, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [511:0]   a_q, b_q;
    logic           two_q;
    logic [58:0]    e_q;
    logic [56:0]    blk_q;
    logic [5:0]     wcnt_q, rem_q;
    logic [1:0]     lwb_q;
    logic           nzero_q, err_q;
    logic [WIDTH-1:0] msg_q;
    logic           vld_q, last_q;
    logic [1:0]     obyte_q;

    logic           acc, ld, free;
    logic [63:0]    len;
    logic [60:0]    n_bytes;
    logic [59:0]    t_words, diff;
    logic [5:0]     cap, r_new;
    logic           chk_fail;
    logic [511:0]   src_blk;
    logic [31:0]    cur_word, fin_mask;
    logic           is_fin;

    // Tail length is resolved at the accept of the last block, while L is on block_in.
    assign len     = block_in[63:0];
    assign n_bytes = len[63:3];
    assign t_words = 60'((62'(n_bytes) + 62'd3) >> 2);
    assign diff    = t_words - {1'b0, e_q};
    assign cap     = (state_q == S_WAIT) ? 6'd32 : 6'd16;
    assign r_new   = (t_words <= {1'b0, e_q}) ? '0 :
                     (diff >= 60'(cap)) ? cap : diff[5:0];

`ifdef MSG_UNPAD_CHECK_EN
    logic [1023:0] win;
    logic [56:0]   blk_exp;
    logic [6:0]    pos;

    // Marker sits in the last block unless it spilled past byte 55, then it is in A.
    always_comb begin
        win      = {a_q, block_in};
        blk_exp  = 57'((({1'b0, len} + 65'd64) >> 9) + 65'd1);
        pos      = (n_bytes[5:0] < 6'd56) ? {1'b1, n_bytes[5:0]} : {1'b0, n_bytes[5:0]};
        chk_fail = (len[2:0] != 3'd0) || ((blk_q + 57'd1) != blk_exp);
        for (int unsigned k = 0; k < 120; k++) begin
            if ((7'(k) == pos) && (win[1023-8*k -: 8] != 8'h80)) chk_fail = 1'b1;
            if ((7'(k) > pos) && (win[1023-8*k -: 8] != 8'h00)) chk_fail = 1'b1;
        end
    end
`else
    logic unused_len_bits;
    assign unused_len_bits = ^len[2:0];
    assign chk_fail        = 1'b0;
`endif

    assign free     = !vld_q || msg_ready_in;
    assign src_blk  = ((state_q == S_TAIL) && (!two_q || wcnt_q[4])) ? b_q : a_q;
    assign cur_word = src_blk[{~wcnt_q[3:0], 5'd0} +: 32];
    assign is_fin   = (state_q == S_TAIL) && (wcnt_q == rem_q - 6'd1);

    always_comb begin
        case (lwb_q)
            2'd0:    fin_mask = 32'hFF00_0000;
            2'd1:    fin_mask = 32'hFFFF_0000;
            2'd2:    fin_mask = 32'hFFFF_FF00;
            default: fin_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        block_ready_out = 1'b0;
        ld              = 1'b0;
        case (state_q)
            S_IDLE: begin
                block_ready_out = 1'b1;
                if (block_valid_in) state_d = block_last_in ? S_TAIL : S_WAIT;
            end
            S_WAIT: begin
                block_ready_out = 1'b1;
                if (block_valid_in) state_d = block_last_in ? S_TAIL : S_EMIT;
            end
            S_EMIT: if (free) begin
                if (wcnt_q == 6'd16) state_d = S_WAIT;
                else                 ld = 1'b1;
            end
            S_TAIL: if (free) begin
                if (wcnt_q == rem_q) state_d = S_DONE;
                else                 ld = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        acc = block_ready_out && block_valid_in;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            a_q <= '0; b_q <= '0; two_q <= 1'b0; e_q <= '0; blk_q <= '0;
            wcnt_q <= '0; rem_q <= '0; lwb_q <= '0; nzero_q <= 1'b0; err_q <= 1'b0;
            msg_q <= '0; vld_q <= 1'b0; last_q <= 1'b0; obyte_q <= '0;
        end else begin
            if (acc) begin
                blk_q <= blk_q + 57'd1;
                if (state_q == S_IDLE) begin
                    err_q <= block_last_in && chk_fail;
                    if (block_last_in) b_q <= block_in;
                    else               a_q <= block_in;
                end else begin
                    b_q <= block_in;
                    if (block_last_in) err_q <= err_q | chk_fail;
                end
                if (block_last_in) begin
                    two_q   <= (state_q == S_WAIT);
                    rem_q   <= chk_fail ? '0 : r_new;
                    lwb_q   <= 2'(n_bytes - 61'd1);
                    nzero_q <= (n_bytes == '0);
                end
            end
            if (ld) begin
                wcnt_q <= wcnt_q + 6'd1;
                e_q    <= e_q + 59'd1;
            end
            if ((state_q == S_EMIT) && (state_d == S_WAIT)) begin
                a_q    <= b_q;
                wcnt_q <= '0;
            end
            if ((state_q == S_TAIL) && (state_d == S_DONE)) wcnt_q <= '0;
            if (state_q == S_DONE) begin
                e_q   <= '0;
                blk_q <= '0;
            end
            if (ld) begin
                vld_q   <= 1'b1;
                msg_q   <= is_fin ? (cur_word & fin_mask) : cur_word;
                last_q  <= is_fin;
                obyte_q <= is_fin ? lwb_q : 2'd0;
            end else if (msg_ready_in) begin
                vld_q   <= 1'b0;
                msg_q   <= '0;
                last_q  <= 1'b0;
                obyte_q <= '0;
            end
        end
    end

    assign msg_out            = msg_q;
    assign msg_valid_out      = vld_q;
    assign is_last_word_out   = last_q;
    assign last_word_byte_out = obyte_q;
    assign unpad_done_out     = (state_q == S_DONE);
    assign msg_empty_out      = (state_q == S_DONE) && nzero_q;
    assign pad_error_out      = err_q;

endmodule
